// File: rtl/masked_pkg.sv
// Shared definitions for the masked AND arbiter: FSM state encoding,
// LFSR geometry, default seed, feedback taps and the LFSR step function.
package masked_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

  // Fibonacci feedback taps, XORed together and shifted in at bit 0.
  localparam int TAP0 = 15;
  localparam int TAP1 = 13;
  localparam int TAP2 = 12;
  localparam int TAP3 = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], l[TAP0] ^ l[TAP1] ^ l[TAP2] ^ l[TAP3]};
  endfunction

endpackage

// File: rtl/and_gate_masked.sv
// First-order masked AND core (domain-oriented style), purely combinational.
// Ports:
//   a0_i, a1_i : Boolean shares of A
//   b0_i, b1_i : Boolean shares of B
//   r_i        : one fresh random bit that masks the cross-domain terms
//   y0_o, y1_o : output shares, y0_o ^ y1_o = A & B
// Each output share only combines its own domain's share with one
// cross-domain product, and the cross products are always masked by r_i,
// so a0/a1 and b0/b1 are never combined with each other directly.
module and_gate_masked (
  input  logic a0_i,
  input  logic a1_i,
  input  logic b0_i,
  input  logic b1_i,
  input  logic r_i,
  output logic y0_o,
  output logic y1_o
);

  assign y0_o = (a0_i & b0_i) ^ ((a0_i & b1_i) ^ r_i);
  assign y1_o = (a1_i & b1_i) ^ ((a1_i & b0_i) ^ r_i);

endmodule

// File: rtl/masked_and_arbiter.sv
// Two-requester front end for a masked AND core.
// A round-robin arbiter accepts one operation in IDLE, the captured shares
// are evaluated in EVAL with a fresh LFSR bit, and the result is held in
// RESP until the consumer takes it.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid / reqN_ready   : per-requester handshake (N = 0, 1)
//   reqN_a0/a1/b0/b1          : per-requester input shares
//   seed_load, seed           : LFSR reseed (IDLE only; zero maps to LFSR_SEED)
//   rsp_valid / rsp_ready     : response handshake
//   rsp_id, rsp_y0, rsp_y1    : response owner and output shares
//   busy                      : FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; grants one and captures its shares
// EVAL  | core evaluates captured shares with r = lfsr[0]; LFSR advances
// RESP  | response held until rsp_ready
module masked_and_arbiter
  import masked_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_a0,
  input  logic              req0_a1,
  input  logic              req0_b0,
  input  logic              req0_b1,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_a0,
  input  logic              req1_a1,
  input  logic              req1_b0,
  input  logic              req1_b1,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic              rsp_y0,
  output logic              rsp_y1,
  output logic              busy
);

  state_e            state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              last_grant_q;
  logic              a0_q, a1_q, b0_q, b1_q;
  logic              id_q;
  logic              rsp_valid_q, rsp_id_q, rsp_y0_q, rsp_y1_q;

  logic              grant_vld;
  logic              grant_id;
  logic              core_y0, core_y1;

  // Round-robin: on contention the requester not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld &  grant_id;

  // A seed loaded alongside a grant is visible in EVAL, so that operation
  // uses the new seed's bit 0. Stepping only in EVAL gives one bit per op.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_IDLE && seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_SEED : seed;
    end else if (state_q == ST_EVAL) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  and_gate_masked u_core (
    .a0_i (a0_q),
    .a1_i (a1_q),
    .b0_i (b0_q),
    .b1_i (b1_q),
    .r_i  (lfsr_q[0]),
    .y0_o (core_y0),
    .y1_o (core_y1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_SEED;
      last_grant_q <= 1'b1;
      a0_q         <= 1'b0;
      a1_q         <= 1'b0;
      b0_q         <= 1'b0;
      b1_q         <= 1'b0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y0_q     <= 1'b0;
      rsp_y1_q     <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            // Shares stay in separate registers; the mux only selects a source.
            a0_q         <= grant_id ? req1_a0 : req0_a0;
            a1_q         <= grant_id ? req1_a1 : req0_a1;
            b0_q         <= grant_id ? req1_b0 : req0_b0;
            b1_q         <= grant_id ? req1_b1 : req0_b1;
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            state_q      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          rsp_y0_q    <= core_y0;
          rsp_y1_q    <= core_y1;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y0    = rsp_y0_q;
  assign rsp_y1    = rsp_y1_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/masked_and_arbiter.md
MASKED_AND_ARBITER -- requirements
Module: masked_and_arbiter

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, reset/fallback value of the randomness LFSR.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 reqN_a0, reqN_a1, reqN_b0, reqN_b1  input  1 each  Boolean shares of A and B from requester N.
REQ-007 seed_load  input  1  load seed into the LFSR.
REQ-008 seed  input  16  LFSR seed value.
REQ-009 rsp_valid  output  1  a response is held.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  index of the requester that owns the response.
REQ-012 rsp_y0, rsp_y1  output  1 each  output shares; rsp_y0^rsp_y1 = (a0^a1)&(b0^b1).
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, EVAL and RESP.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally for that cycle, capture its four shares and its id into separate per-share registers, and go to EVAL.
REQ-016 Arbitration SHALL be round-robin: if both requests are valid, grant the requester not granted last; if only one is valid, grant it.
REQ-017 reqN_ready SHALL be asserted only in IDLE, and for at most one requester per cycle.
REQ-018 EVAL: the captured shares plus rN = lfsr[0] SHALL drive the masked AND core.
REQ-019 In EVAL, core outputs SHALL be registered into rsp_y0/rsp_y1.
REQ-020 In EVAL, the LFSR SHALL advance exactly once, and the FSM SHALL go to RESP.
REQ-021 LFSR: 16-bit Fibonacci shift-left, feedback = l[15]^l[13]^l[12]^l[10], inserted at bit 0.
REQ-022 The LFSR SHALL advance only in EVAL, so each operation consumes a fresh rN.
REQ-023 RESP: rsp_valid=1 with rsp_y0/y1/id stable until rsp_ready=1; on the handshake cycle go to IDLE.
REQ-024 Latency: accept at cycle t gives rsp_valid at t+2; the minimum spacing between accepts is 3 cycles.
REQ-025 Shares SHALL never be recombined outside the core; no logic SHALL XOR a0 with a1 or b0 with b1.
REQ-026 seed_load SHALL take effect only in IDLE and SHALL be ignored in EVAL and RESP.
REQ-027 seed_load together with a grant in the same IDLE cycle: the loaded seed is used for that operation's rN.
REQ-028 seed == 0 SHALL load LFSR_SEED instead, which prevents lock-up.
REQ-029 Requests that drop before being granted SHALL be ignored, with no state change.

Reset
REQ-030 On rst: state=IDLE, lfsr=LFSR_SEED, last_grant=1 (so req0 wins first), rsp_valid=0, rsp_id=0, rsp_y0=rsp_y1=0, share registers=0, busy=0, reqN_ready=0.
REQ-031 rst SHALL override all other inputs, including a simultaneous seed_load or grant.
REQ-032 rst in EVAL or RESP SHALL discard the operation: no response, and the LFSR is restored to LFSR_SEED.

Structure
REQ-033 Package masked_pkg SHALL hold the state enum, LFSR width (16), the default seed and the tap positions.
REQ-034 The block SHALL instantiate exactly one existing and_gate_masked core as its sub-module.
REQ-035 All other logic (arbiter, FSM, LFSR, capture and response registers) SHALL be inline.

Verification
REQ-036 Reset, then req0 only with shares A=(1,0), B=(0,1) -> req0_ready at t, rsp_valid at t+2, rsp_id=0, rsp_y0^rsp_y1=1.
REQ-037 Both requesters continuously valid, rsp_ready=1 -> grant order 0,1,0,1, accepts spaced exactly 3 cycles.
REQ-038 seed_load=1 with seed=16'h0001 in IDLE, then three operations -> rN sequence 1,0,0, and the LFSR ends at 16'h0008.
REQ-039 seed_load with seed=0 -> LFSR=16'hACE1; seed_load asserted during EVAL -> no effect.
REQ-040 rsp_ready held low for 5 cycles in RESP -> outputs stable, no reqN_ready, busy=1; rsp_ready=1 -> IDLE next cycle.
REQ-041 rst asserted during EVAL -> no rsp_valid, all outputs at reset values, LFSR=16'hACE1.
REQ-042 Random sweep of 1000 operations -> every response satisfies y0^y1 = (a0^a1)&(b0^b1), and no two consecutive operations see the same LFSR state.
